// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcode and shift encodings,
// FSM states, instruction field positions and flag bit indices.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
      OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
      OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
      OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
   } alu_op_e;

   // shift_op[2:1] selects the kind, shift_op[0] selects a register amount
   typedef enum logic [1:0] {
      SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
   } shift_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0, ST_READ = 2'd1, ST_EXEC = 2'd2, ST_WB = 2'd3
   } state_e;

   localparam int F_OP_LSB  = 28;
   localparam int F_S       = 27;
   localparam int F_SH_LSB  = 24;
   localparam int F_IMM_LSB = 16;
   localparam int F_RD_LSB  = 12;
   localparam int F_RN_LSB  = 8;
   localparam int F_RM_LSB  = 4;
   localparam int F_RS_LSB  = 0;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic is_test_op(input alu_op_e op);
      return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
   endfunction

endpackage

// File: rtl/cpu_core_mc_if.sv
// Instruction handshake and write-back/status bundle of cpu_core_mc.
interface cpu_core_mc_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 6,
   parameter int CNT_W  = 16
) ();
   logic [31:0]       inst;
   logic              inst_valid;
   logic              inst_ready;
   logic [PC_W-1:0]   pc;
   logic              wb_valid;
   logic              wb_we;
   logic [3:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [3:0]        flags;
   logic [CNT_W-1:0]  retired;

   modport master (
      output inst, inst_valid,
      input  inst_ready, pc, wb_valid, wb_we, wb_addr, wb_data, flags, retired
   );

   modport slave (
      input  inst, inst_valid,
      output inst_ready, pc, wb_valid, wb_we, wb_addr, wb_data, flags, retired
   );
endinterface

// File: rtl/cpu_shifter.sv
// Combinational barrel shifter (LSL/LSR/ASR/ROR) with carry-out.
module cpu_shifter
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] value,
   input  logic [7:0]        amount,
   input  shift_kind_e       kind,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              carry_out
);
   localparam int         SH_W = $clog2(DATA_W);
   localparam logic [7:0] W8   = 8'(DATA_W);

   logic [DATA_W:0]   lsl_s;
   logic [DATA_W:0]   lsr_s;
   logic [DATA_W:0]   asr_s;
   logic [DATA_W-1:0] ror_s;
   logic [SH_W-1:0]   rot_s;

   // The extra bit on each shift catches the last bit shifted out as carry
   always_comb begin
      lsl_s     = {1'b0, value} << amount;
      lsr_s     = {value, 1'b0} >> amount;
      asr_s     = $signed({value, 1'b0}) >>> amount;
      rot_s     = amount[SH_W-1:0];
      ror_s     = (value >> rot_s) | (value << (DATA_W - int'(rot_s)));
      result    = value;
      carry_out = carry_in;
      if (amount == 8'd0) begin
         result    = value;
         carry_out = carry_in;
      end else begin
         case (kind)
            SH_LSL: begin
               if (amount > W8) begin
                  result    = '0;
                  carry_out = 1'b0;
               end else begin
                  result    = lsl_s[DATA_W-1:0];
                  carry_out = lsl_s[DATA_W];
               end
            end
            SH_LSR: begin
               if (amount > W8) begin
                  result    = '0;
                  carry_out = 1'b0;
               end else begin
                  result    = lsr_s[DATA_W:1];
                  carry_out = lsr_s[0];
               end
            end
            SH_ASR: begin
               if (amount >= W8) begin
                  result    = {DATA_W{value[DATA_W-1]}};
                  carry_out = value[DATA_W-1];
               end else begin
                  result    = asr_s[DATA_W:1];
                  carry_out = asr_s[0];
               end
            end
            SH_ROR: begin
               result    = ror_s;
               carry_out = ror_s[DATA_W-1];
            end
            default: begin
               result    = value;
               carry_out = carry_in;
            end
         endcase
      end
   end
endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle core: IDLE -> READ -> EXEC -> WB per instruction, with register
// file, NZCV flags, barrel shifter and ALU behind a valid/ready fetch port.
module cpu_core_mc
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int PC_W   = 6,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   cpu_core_mc_if.slave bus
);
   state_e            state_r, state_nx;
   logic [31:0]       inst_r;
   logic [DATA_W-1:0] regs_r [NREG];
   logic [DATA_W-1:0] opa_r, opm_r;
   logic [7:0]        ops_r;
   logic [3:0]        flags_nx_r;

   logic              inst_ready_r, wb_valid_r, wb_we_r;
   logic [PC_W-1:0]   pc_r;
   logic [3:0]        wb_addr_r, flags_r;
   logic [DATA_W-1:0] wb_data_r;
   logic [CNT_W-1:0]  retired_r;

   logic              accept_s;
   alu_op_e           op_s;
   logic [2:0]        shop_s;
   logic [3:0]        rd_s, rn_s, rm_s, rs_s;
   logic [DATA_W-1:0] rn_val_s, rm_val_s, sh_res_s, res_s, x_s, y_s;
   logic [7:0]        rs_amt_s, amount_s;
   logic              sh_carry_s, cin_s, arith_s, test_s, we_s;
   logic [DATA_W:0]   sum_s;
   logic [3:0]        flags_new_s, flags_next_s;

   assign op_s     = alu_op_e'(inst_r[F_OP_LSB +: 4]);
   assign shop_s   = inst_r[F_SH_LSB +: 3];
   assign rd_s     = inst_r[F_RD_LSB +: 4];
   assign rn_s     = inst_r[F_RN_LSB +: 4];
   assign rm_s     = inst_r[F_RM_LSB +: 4];
   assign rs_s     = inst_r[F_RS_LSB +: 4];
   assign amount_s = shop_s[0] ? ops_r : inst_r[F_IMM_LSB +: 8];
   assign accept_s = bus.inst_valid && (state_r == ST_IDLE);

   assign bus.inst_ready = inst_ready_r;
   assign bus.pc         = pc_r;
   assign bus.wb_valid   = wb_valid_r;
   assign bus.wb_we      = wb_we_r;
   assign bus.wb_addr    = wb_addr_r;
   assign bus.wb_data    = wb_data_r;
   assign bus.flags      = flags_r;
   assign bus.retired    = retired_r;

   // Register read ports; addresses at or above NREG read as zero
   always_comb begin
      rn_val_s = '0;
      rm_val_s = '0;
      rs_amt_s = 8'd0;
      for (int i = 0; i < NREG; i++) begin
         if (rn_s == 4'(i)) rn_val_s = regs_r[i];
         if (rm_s == 4'(i)) rm_val_s = regs_r[i];
         if (rs_s == 4'(i)) rs_amt_s = 8'(regs_r[i]);
      end
   end

   cpu_shifter #(.DATA_W(DATA_W)) u_shifter (
      .value     (opm_r),
      .amount    (amount_s),
      .kind      (shift_kind_e'(shop_s[2:1])),
      .carry_in  (flags_r[FLAG_C]),
      .result    (sh_res_s),
      .carry_out (sh_carry_s)
   );

   // ALU: subtraction is x + ~y + cin, so C is NOT borrow and V uses the adder inputs
   always_comb begin
      x_s     = opa_r;
      y_s     = sh_res_s;
      cin_s   = 1'b0;
      arith_s = 1'b0;
      res_s   = '0;
      case (op_s)
         OP_AND, OP_TST: res_s = opa_r & sh_res_s;
         OP_EOR, OP_TEQ: res_s = opa_r ^ sh_res_s;
         OP_SUB, OP_CMP: begin y_s = ~sh_res_s; cin_s = 1'b1; arith_s = 1'b1; end
         OP_RSB:         begin x_s = sh_res_s; y_s = ~opa_r; cin_s = 1'b1; arith_s = 1'b1; end
         OP_ADD, OP_CMN: arith_s = 1'b1;
         OP_ADC:         begin cin_s = flags_r[FLAG_C]; arith_s = 1'b1; end
         OP_SBC:         begin y_s = ~sh_res_s; cin_s = flags_r[FLAG_C]; arith_s = 1'b1; end
         OP_RSC:         begin x_s = sh_res_s; y_s = ~opa_r; cin_s = flags_r[FLAG_C]; arith_s = 1'b1; end
         OP_ORR:         res_s = opa_r | sh_res_s;
         OP_MOV:         res_s = sh_res_s;
         OP_BIC:         res_s = opa_r & ~sh_res_s;
         OP_MVN:         res_s = ~sh_res_s;
         default:        res_s = '0;
      endcase
      sum_s = {1'b0, x_s} + {1'b0, y_s} + (DATA_W+1)'(cin_s);
      if (arith_s) begin
         res_s = sum_s[DATA_W-1:0];
      end else begin
         res_s = res_s;
      end
      test_s = is_test_op(op_s);
      we_s   = !test_s;
      flags_new_s[FLAG_N] = res_s[DATA_W-1];
      flags_new_s[FLAG_Z] = (res_s == '0);
      flags_new_s[FLAG_C] = arith_s ? sum_s[DATA_W] : sh_carry_s;
      flags_new_s[FLAG_V] = arith_s ? ((x_s[DATA_W-1] == y_s[DATA_W-1]) &&
                                       (res_s[DATA_W-1] != x_s[DATA_W-1]))
                                    : flags_r[FLAG_V];
      if (inst_r[F_S] || test_s) begin
         flags_next_s = flags_new_s;
      end else begin
         flags_next_s = flags_r;
      end
   end

   // FSM next state
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nx = ST_READ;
            else          state_nx = ST_IDLE;
         end
         ST_READ: state_nx = ST_EXEC;
         ST_EXEC: state_nx = ST_WB;
         ST_WB:   state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx;
   end

   // Register file write port, committed on the WB closing edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_r[i] <= '0;
      end else if ((state_r == ST_WB) && wb_we_r) begin
         for (int i = 0; i < NREG; i++) begin
            if (wb_addr_r == 4'(i)) regs_r[i] <= wb_data_r;
         end
      end
   end

   // Datapath pipeline registers and status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_r       <= 32'd0;
         pc_r         <= '0;
         opa_r        <= '0;
         opm_r        <= '0;
         ops_r        <= 8'd0;
         flags_nx_r   <= 4'd0;
         flags_r      <= 4'd0;
         retired_r    <= '0;
         wb_we_r      <= 1'b0;
         wb_addr_r    <= 4'd0;
         wb_data_r    <= '0;
         inst_ready_r <= 1'b1;
         wb_valid_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  inst_r <= bus.inst;
                  pc_r   <= pc_r + PC_W'(1);
               end
            end
            ST_READ: begin
               opa_r <= rn_val_s;
               opm_r <= rm_val_s;
               ops_r <= rs_amt_s;
            end
            ST_EXEC: begin
               wb_data_r  <= res_s;
               wb_we_r    <= we_s;
               wb_addr_r  <= rd_s;
               flags_nx_r <= flags_next_s;
            end
            ST_WB: begin
               flags_r   <= flags_nx_r;
               retired_r <= retired_r + CNT_W'(1);
            end
            default: begin
               inst_r <= inst_r;
            end
         endcase
         inst_ready_r <= (state_nx == ST_IDLE);
         wb_valid_r   <= (state_nx == ST_WB);
      end
   end
endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed self-checking bench for cpu_core_mc (DATA_W=32, NREG=16, PC_W=6).
module tb_cpu_core_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   exp_pc = 0;
   int   exp_ret = 0;

   logic [31:0] r_data;
   logic        r_we;
   logic [3:0]  r_addr;
   logic [3:0]  r_flags;
   int          r_lat;

   cpu_core_mc_if #(.DATA_W(32), .PC_W(6), .CNT_W(16)) bus ();

   cpu_core_mc #(.DATA_W(32), .NREG(16), .PC_W(6), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [3:0] op, input logic s, input logic [2:0] sh,
                                       input logic [7:0] imm, input logic [3:0] rd, input logic [3:0] rn,
                                       input logic [3:0] rm, input logic [3:0] rs);
      return {op, s, sh, imm, rd, rn, rm, rs};
   endfunction

   // Issue one instruction from a negedge in IDLE; returns at the negedge after retirement
   task automatic run_inst(input logic [31:0] w);
      int k;
      k = 0;
      while (bus.inst_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      bus.inst = w;
      bus.inst_valid = 1'b1;
      @(posedge clk); #1;
      bus.inst_valid = 1'b0;
      r_lat = 0;
      do begin @(negedge clk); r_lat++; end while (bus.wb_valid !== 1'b1 && r_lat < 10);
      r_data = bus.wb_data;
      r_we   = bus.wb_we;
      r_addr = bus.wb_addr;
      @(negedge clk);
      r_flags = bus.flags;
      exp_pc  = (exp_pc + 1) % 64;
      exp_ret = exp_ret + 1;
   endtask

   task automatic test_reset();
      bus.inst = 32'd0;
      bus.inst_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.inst_ready, bus.wb_valid, bus.wb_we, bus.wb_addr, bus.flags} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
         failures++;
         $display("FAIL reset_ctrl got rdy=%b wbv=%b we=%b addr=%h flags=%b", bus.inst_ready, bus.wb_valid, bus.wb_we, bus.wb_addr, bus.flags);
      end
      checks++;
      if ({bus.pc, bus.retired, bus.wb_data} !== {6'd0, 16'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_vals got pc=%0d ret=%0d data=%h exp 0/0/0", bus.pc, bus.retired, bus.wb_data);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.inst_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.inst_ready); end
   endtask

   task automatic test_mvn();
      run_inst(enc(4'hF, 1'b0, 3'b000, 8'd0, 4'd1, 4'd0, 4'd0, 4'd0));
      checks++;
      if (r_lat !== 3) begin failures++; $display("FAIL mvn_latency got=%0d exp=3", r_lat); end
      checks++;
      if ({r_we, r_addr, r_data} !== {1'b1, 4'd1, 32'hFFFF_FFFF}) begin
         failures++; $display("FAIL mvn_wb got we=%b addr=%0d data=%h exp 1/1/ffffffff", r_we, r_addr, r_data);
      end
      checks++;
      if ({bus.pc, bus.retired, r_flags} !== {6'd1, 16'd1, 4'b0000}) begin
         failures++; $display("FAIL mvn_status got pc=%0d ret=%0d flags=%b exp 1/1/0000", bus.pc, bus.retired, r_flags);
      end
   endtask

   task automatic test_shift_mov();
      run_inst(enc(4'hD, 1'b0, 3'b010, 8'd28, 4'd2, 4'd0, 4'd1, 4'd0));
      checks++;
      if (r_data !== 32'h0000_000F) begin failures++; $display("FAIL mov_lsr28 got=%h exp=0000000f", r_data); end
      run_inst(enc(4'h4, 1'b0, 3'b000, 8'd4, 4'd3, 4'd2, 4'd2, 4'd0));
      checks++;
      if (r_data !== 32'h0000_00FF) begin failures++; $display("FAIL add_lsl4 got=%h exp=000000ff", r_data); end
      run_inst(enc(4'hD, 1'b0, 3'b010, 8'd26, 4'd8, 4'd0, 4'd1, 4'd0));
      checks++;
      if (r_data !== 32'h0000_003F) begin failures++; $display("FAIL mov_lsr26 got=%h exp=0000003f", r_data); end
   endtask

   task automatic test_flags();
      run_inst(enc(4'h4, 1'b1, 3'b000, 8'd0, 4'd4, 4'd1, 4'd1, 4'd0));
      checks++;
      if ({r_data, r_flags} !== {32'hFFFF_FFFE, 4'b1010}) begin
         failures++; $display("FAIL adds got data=%h flags=%b exp fffffffe/1010", r_data, r_flags);
      end
      run_inst(enc(4'hA, 1'b0, 3'b000, 8'd0, 4'd0, 4'd1, 4'd1, 4'd0));
      checks++;
      if ({r_we, r_flags} !== {1'b0, 4'b0110}) begin
         failures++; $display("FAIL cmp got we=%b flags=%b exp 0/0110", r_we, r_flags);
      end
      run_inst(enc(4'hD, 1'b0, 3'b000, 8'd0, 4'd7, 4'd0, 4'd1, 4'd0));
      checks++;
      if (r_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cmp_keeps_r1 got=%h exp=ffffffff", r_data); end
      run_inst(enc(4'h5, 1'b0, 3'b000, 8'd0, 4'd5, 4'd0, 4'd0, 4'd0));
      checks++;
      if ({r_data, r_flags} !== {32'h0000_0001, 4'b0110}) begin
         failures++; $display("FAIL adc got data=%h flags=%b exp 00000001/0110", r_data, r_flags);
      end
   endtask

   task automatic test_shift_edges();
      run_inst(enc(4'hD, 1'b1, 3'b001, 8'd0, 4'd9, 4'd0, 4'd1, 4'd8));
      checks++;
      if ({r_data, r_flags} !== {32'h0, 4'b0100}) begin
         failures++; $display("FAIL lsl_reg63 got data=%h flags=%b exp 00000000/0100", r_data, r_flags);
      end
      run_inst(enc(4'hA, 1'b0, 3'b000, 8'd0, 4'd0, 4'd1, 4'd1, 4'd0));
      run_inst(enc(4'hD, 1'b1, 3'b111, 8'd0, 4'd10, 4'd0, 4'd1, 4'd0));
      checks++;
      if ({r_data, r_flags} !== {32'hFFFF_FFFF, 4'b1010}) begin
         failures++; $display("FAIL ror_zero got data=%h flags=%b exp ffffffff/1010", r_data, r_flags);
      end
      run_inst(enc(4'hD, 1'b1, 3'b010, 8'd32, 4'd11, 4'd0, 4'd1, 4'd0));
      checks++;
      if ({r_data, r_flags} !== {32'h0, 4'b0110}) begin
         failures++; $display("FAIL lsr32 got data=%h flags=%b exp 00000000/0110", r_data, r_flags);
      end
      run_inst(enc(4'h2, 1'b1, 3'b000, 8'd31, 4'd13, 4'd0, 4'd1, 4'd0));
      checks++;
      if ({r_data, r_flags} !== {32'h8000_0000, 4'b1001}) begin
         failures++; $display("FAIL subs_ovf got data=%h flags=%b exp 80000000/1001", r_data, r_flags);
      end
      run_inst(enc(4'hD, 1'b1, 3'b100, 8'd40, 4'd12, 4'd0, 4'd1, 4'd0));
      checks++;
      if ({r_data, r_flags} !== {32'hFFFF_FFFF, 4'b1011}) begin
         failures++; $display("FAIL asr40 got data=%h flags=%b exp ffffffff/1011", r_data, r_flags);
      end
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      bus.inst_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.pc !== 6'(exp_pc) || bus.inst_ready !== 1'b1 || bus.wb_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL idle_hold got bad_cycles=%0d exp=0 (pc=%0d exp=%0d)", bad, bus.pc, exp_pc); end
   endtask

   task automatic test_back_to_back();
      int acc, prev, gap_bad, wbs;
      acc = 0; prev = -1; gap_bad = 0; wbs = 0;
      bus.inst = enc(4'hD, 1'b0, 3'b000, 8'd0, 4'd7, 4'd0, 4'd1, 4'd0);
      bus.inst_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (bus.inst_ready === 1'b1) begin
            acc++;
            if (prev >= 0 && (c - prev) != 4) gap_bad++;
            prev = c;
         end
         if (bus.wb_valid === 1'b1) wbs++;
         @(negedge clk);
      end
      bus.inst_valid = 1'b0;
      exp_pc  = (exp_pc + 5) % 64;
      exp_ret = exp_ret + 5;
      checks++;
      if ({acc, gap_bad, wbs} !== {32'd5, 32'd0, 32'd5}) begin
         failures++; $display("FAIL burst got accepts=%0d gap_err=%0d wb=%0d exp 5/0/5", acc, gap_bad, wbs);
      end
      checks++;
      if ({bus.pc, bus.retired} !== {6'(exp_pc), 16'(exp_ret)}) begin
         failures++; $display("FAIL burst_status got pc=%0d ret=%0d exp %0d/%0d", bus.pc, bus.retired, exp_pc, exp_ret);
      end
   endtask

   task automatic test_reset_abort();
      bus.inst = enc(4'h4, 1'b0, 3'b000, 8'd4, 4'd3, 4'd2, 4'd2, 4'd0);
      bus.inst_valid = 1'b1;
      @(posedge clk); #1;
      bus.inst_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_pc = 0;
      exp_ret = 0;
      checks++;
      if ({bus.pc, bus.retired, bus.flags, bus.wb_valid, bus.inst_ready} !== {6'd0, 16'd0, 4'd0, 1'b0, 1'b1}) begin
         failures++; $display("FAIL abort_status got pc=%0d ret=%0d flags=%b wbv=%b rdy=%b exp 0/0/0000/0/1",
                              bus.pc, bus.retired, bus.flags, bus.wb_valid, bus.inst_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      run_inst(enc(4'hD, 1'b0, 3'b000, 8'd0, 4'd6, 4'd0, 4'd3, 4'd0));
      checks++;
      if ({r_data, r_lat} !== {32'h0, 32'd3}) begin
         failures++; $display("FAIL abort_r3 got data=%h lat=%0d exp 00000000/3", r_data, r_lat);
      end
      checks++;
      if ({bus.pc, bus.retired} !== {6'd1, 16'd1}) begin
         failures++; $display("FAIL abort_next got pc=%0d ret=%0d exp 1/1", bus.pc, bus.retired);
      end
   endtask

   initial begin
      test_reset();
      test_mvn();
      test_shift_mov();
      test_flags();
      test_shift_edges();
      test_idle();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_core_mc.md
# cpu_core_mc

Parametrised multi-cycle core that replaces the single-cycle fetch/decode/ALU top. It holds the program counter, the register file, the NZCV flags, a barrel shifter and the ALU behind one FSM. Instructions arrive over a valid/ready handshake, so the instruction source can stall. Each instruction takes four cycles and reports its write-back and retirement on a status port.

## Interface
Parameters:
- DATA_W, 32, datapath and register width; must be one of 8/16/32/64.
- NREG, 16, number of registers; must be 2..16. Register addresses ≥ NREG read 0 and ignore writes.
- PC_W, 6, program counter width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset: asynchronous, active-high.
- inst, in, 32, instruction word.
- inst_valid, in, 1, instruction present.
- inst_ready, out, 1, core can accept an instruction.
- pc, out, PC_W, address of the next instruction to request.
- wb_valid, out, 1, write-back/retire strobe, one cycle.
- wb_we, out, 1, register write occurs this retire; 0 for TST/TEQ/CMP/CMN.
- wb_addr, out, 4, destination register.
- wb_data, out, DATA_W, result value.
- flags, out, 4, NZCV register.
- retired, out, CNT_W, retired-instruction count.

## Operation
- Instruction fields:
  - [31:28] alu_op
  - [27] S (update flags)
  - [26:24] shift_op
  - [23:16] shamt_imm
  - [15:12] rd
  - [11:8] rn, the ALU A operand
  - [7:4] rm, the value that is shifted
  - [3:0] rs, the register shift amount
- Shift operations (shift_op[0]=1 takes the amount from R[rs][7:0], else from shamt_imm):
  - 00x LSL, 01x LSR, 10x ASR, 11x ROR.
- Shifter rules, with n = amount and W = DATA_W:
  - n=0: result = R[rm], shifter carry = current C.
  - LSL/LSR with 1≤n≤W: normal shift; carry = last bit shifted out.
  - LSL/LSR with n>W: result 0, carry 0.
  - ASR with n≥W: result all sign bits, carry = sign.
  - ROR: rotate by n mod W; carry = result MSB.
- ALU operations, with B = shifter output:
  - 0 AND, 1 EOR, 2 SUB A−B, 3 RSB B−A
  - 4 ADD, 5 ADC, 6 SBC A−B−!C, 7 RSC
  - 8 TST, 9 TEQ, 10 CMP, 11 CMN
  - 12 ORR, 13 MOV (B), 14 BIC, 15 MVN.
- ALU result rules:
  - Ops 8–11 never write a register and always update flags regardless of S.
  - Arithmetic ops: C = carry out of DATA_W (for subtraction, C = NOT borrow); V = signed overflow.
  - Logical ops: C = shifter carry; V unchanged.
  - N = result MSB; Z = (result == 0).
  - With S=0 (ops 0–7, 12–15) the flags are unchanged.
- FSM states:
  - IDLE: inst_ready=1. When inst_valid & inst_ready, latch inst, pc ← pc+1 (wraps modulo 2^PC_W), go to READ. Otherwise stay in IDLE.
  - READ: latch R[rn], R[rm], R[rs]; go to EXEC.
  - EXEC: compute shifter and ALU; latch result, next flags and write enable; go to WB.
  - WB: wb_valid=1. On the closing edge: write R[rd] if wb_we, update flags if required, retired+1 (wraps); go to IDLE.
- A read of a register written by the previous instruction returns the new value. One instruction is in flight at a time, so there are no hazards.

## Timing
- Handshake accepted at edge T. READ runs T..T+1, EXEC T+1..T+2, WB T+2..T+3.
- wb_valid is high in the cycle before edge T+3. Register and flag updates are visible from edge T+3.
- inst_ready returns to 1 after edge T+3. Maximum throughput is one instruction per 4 cycles.
- inst_ready is a function of state only and does not depend on inst_valid. inst is sampled only on the accepting edge.
- Reset values:
  - state IDLE, pc 0, all registers 0, flags 0000, retired 0.
  - inst_ready 1, wb_valid 0, wb_we 0, wb_addr 0, wb_data 0.
- Reset asserted in READ, EXEC or WB aborts the instruction: no write, no flag update, no retire count.
- wb_addr, wb_data and wb_we hold their last values outside WB and are meaningful only while wb_valid=1.

## Structure
- Shared package cpu_pkg holds:
  - alu_op and shift_op encodings;
  - the FSM state type (IDLE/READ/EXEC/WB);
  - instruction field bit positions;
  - flag bit indices (N=3, Z=2, C=1, V=0).
- One combinational sub-module, cpu_shifter (DATA_W parameter), takes value, amount, shift op and carry-in, and produces result and carry-out. The ALU, register file and FSM stay in cpu_core_mc.

## Test plan
All values below are for DATA_W=32.
- Reset, then MVN r1, r0 → wb_valid 3 cycles after acceptance, r1=0xFFFFFFFF, pc 0→1, retired=1, flags unchanged.
- MOV r2, r1 LSR #28 → r2=0x0000000F. Then ADD r3, r2, r2 LSL #4 → r3=0x000000FF. Then MOV r8, r1 LSR #26 → r8=0x3F.
- ADDS r4, r1, r1 → r4=0xFFFFFFFE, flags NZCV=1010. Then CMP r1, r1 → NZCV=0110, wb_we=0, r1 unchanged. Then ADC r5, r0, r0 → r5=1.
- MOVS r9, r1 LSL r8 (amount 63) → r9=0, NZCV=0100. Then MOVS r10, r1 ROR r0 (amount 0) → r10=0xFFFFFFFF and C holds its prior value.
- inst_valid held low for 10 cycles → state stays IDLE and pc is constant. A burst of valid instructions → one acceptance per 4 cycles.
- rst pulsed during EXEC of ADD r3, … → r3=0, retired=0, pc=0, and the next accept works normally.
